// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: Moore-FSM serial transmitter for the 1010 sequence-detect link.
// A frame is the PRE_PAT sync preamble (MSB-first), then a DATA_W-bit payload
// (MSB-first), then an optional even-parity bit, all on the 1-bit line y.
// The line idles at 0 so that it never forms the preamble between frames.
//
// Handshake: start is a request that is sampled only while the FSM is in IDLE
// (busy=0). An edge with start=1 in IDLE accepts the frame and captures din.
// A request seen while busy=1 (PRE, DATA, PAR or DONE) is dropped, not queued.
// din is a don't-care on every edge except the accepting one.
module seq_pattern_tx #(
   parameter int                 DATA_W    = 8,
   parameter int                 PRE_W     = 4,
   parameter logic [PRE_W-1:0]   PRE_PAT   = 4'b1010,
   parameter bit                 PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   output logic              y,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg
);

   // One counter serves both the preamble and the payload, so it is sized
   // for the longer of the two. It counts down and fires at zero.
   localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   // Preamble zero-extended to the full counter range so that the counter
   // can index it directly without a width mismatch.
   localparam int               PAD_W   = 2 ** CNT_W;
   localparam logic [PAD_W-1:0] PRE_PAD = PAD_W'(PRE_PAT);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nx;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] shift_nx;
   logic              par;
   logic              par_nx;

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         shift <= '0;
         par   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         shift <= shift_nx;
         par   <= par_nx;
      end
   end

   // Next-state, datapath updates and Moore output decode from registers only.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shift_nx = shift;
      par_nx   = par;
      y        = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nx = PRE;
               shift_nx = din;
               cnt_nx   = CNT_W'(PRE_W - 1);
               par_nx   = 1'b0;
            end
         end

         PRE: begin
            busy = 1'b1;
            y    = PRE_PAD[cnt];
            if (cnt == '0) begin
               state_nx = DATA;
               cnt_nx   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end

         DATA: begin
            busy     = 1'b1;
            y        = shift[DATA_W-1];
            shift_nx = shift << 1;
            // Running XOR of the bits already sent; equals the even-parity bit
            // once the whole payload has gone out.
            par_nx   = par ^ shift[DATA_W-1];
            if (cnt == '0) begin
               if (PARITY_EN) begin
                  state_nx = PAR;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end

         PAR: begin
            busy     = 1'b1;
            y        = par;
            state_nx = DONE;
         end

         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Raw state encoding for observation.
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: frame shapes, parity, start handling,
// din capture, mid-frame reset, and a 1010 detector on the line.
module tb_seq_pattern_tx;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic       y;
   logic       busy;
   logic       done;
   logic [2:0] state_dbg;

   logic       start2;
   logic [7:0] din2;
   logic       y2;
   logic       busy2;
   logic       done2;
   logic [2:0] state_dbg2;

   int checks = 0;
   int errors = 0;

   logic [2:0] det_hist = 3'b000;
   int         det_cnt  = 0;
   int         det_base;

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_pattern_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   seq_pattern_tx #(.PARITY_EN(1'b0)) dut_np (
      .clk       (clk),
      .rst       (rst),
      .start     (start2),
      .din       (din2),
      .y         (y2),
      .busy      (busy2),
      .done      (done2),
      .state_dbg (state_dbg2)
   );

   // RX-side overlapping 1010 detector fed from the line
   always @(posedge clk) begin
      if ({det_hist, y} == 4'b1010) det_cnt <= det_cnt + 1;
      det_hist <= {det_hist[1:0], y};
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start must already be set up; the first tick is the accepting edge.
   task automatic run_frame(input string tag, input bit sel, input logic [15:0] bits,
                            input int n, input bit keep_start, input bit scramble);
      tick();
      if (!keep_start) begin
         start  = 1'b0;
         start2 = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (scramble) din = 8'($urandom);
         chk({tag, "_y"},    sel ? y2 : y,       32'(bits[n-1-i]));
         chk({tag, "_busy"}, sel ? busy2 : busy, 32'd1);
         chk({tag, "_done"}, sel ? done2 : done, 32'd0);
         tick();
      end
      chk({tag, "_done_y"},    sel ? y2 : y,       32'd0);
      chk({tag, "_done_done"}, sel ? done2 : done, 32'd1);
      chk({tag, "_done_busy"}, sel ? busy2 : busy, 32'd1);
      tick();
      chk({tag, "_idle_y"},     sel ? y2 : y,                 32'd0);
      chk({tag, "_idle_done"},  sel ? done2 : done,           32'd0);
      chk({tag, "_idle_busy"},  sel ? busy2 : busy,           32'd0);
      chk({tag, "_idle_state"}, sel ? state_dbg2 : state_dbg, 32'd0);
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      din    = 8'h00;
      start2 = 1'b0;
      din2   = 8'h00;
      repeat (3) tick();

      // Reset state
      chk("rst_y",      y,          32'd0);
      chk("rst_busy",   busy,       32'd0);
      chk("rst_done",   done,       32'd0);
      chk("rst_state",  state_dbg,  32'd0);
      chk("rst_np_y",   y2,         32'd0);
      chk("rst_np_st",  state_dbg2, 32'd0);

      // start during reset is not accepted
      start = 1'b1;
      din   = 8'hA5;
      tick();
      chk("rst_start_ignored", state_dbg, 32'd0);

      // Release reset away from the edge with start already high: next edge accepts.
      rst = 1'b1;
      // A5 = 1010_0101, four ones -> parity 0
      run_frame("t2_a5", 1'b0, 16'b1010_1010_0101_0, 13, 1'b0, 1'b0);

      // 07 = 0000_0111, three ones -> parity 1
      din   = 8'h07;
      start = 1'b1;
      run_frame("t3_07", 1'b0, 16'b1010_0000_0111_1, 13, 1'b0, 1'b0);

      // No-parity variant: 12 bits then DONE
      din2   = 8'hFF;
      start2 = 1'b1;
      run_frame("t3_np_ff", 1'b1, 16'b1010_1111_1111, 12, 1'b0, 1'b0);

      // start held high: back-to-back frames with DONE+IDLE zero gap
      din   = 8'h3C;
      start = 1'b1;
      run_frame("t4_a", 1'b0, 16'b1010_0011_1100_0, 13, 1'b1, 1'b0);
      run_frame("t4_b", 1'b0, 16'b1010_0011_1100_0, 13, 1'b1, 1'b0);
      start = 1'b0;
      tick();
      chk("t4_stop_state", state_dbg, 32'd0);
      chk("t4_stop_y",     y,         32'd0);

      // din scrambled every cycle after acceptance of 5A = 0101_1010, parity 0
      din   = 8'h5A;
      start = 1'b1;
      run_frame("t5_5a", 1'b0, 16'b1010_0101_1010_0, 13, 1'b0, 1'b1);

      // Loopback: one detection, at the last preamble bit
      din      = 8'h00;
      start    = 1'b1;
      det_base = det_cnt;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("t6_det_before", 32'(det_cnt - det_base), 32'd0);
      tick();
      chk("t6_det_at_pre_end", 32'(det_cnt - det_base), 32'd1);
      repeat (12) tick();
      chk("t6_det_total", 32'(det_cnt - det_base), 32'd1);
      chk("t6_idle_state", state_dbg, 32'd0);

      // Reset mid-DATA
      din   = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("t1_pre_state", state_dbg, 32'd2);
      chk("t1_pre_y",     y,         32'd1);
      rst = 1'b0;
      #1;
      chk("t1_abort_y",     y,         32'd0);
      chk("t1_abort_busy",  busy,      32'd0);
      chk("t1_abort_done",  done,      32'd0);
      chk("t1_abort_state", state_dbg, 32'd0);
      repeat (2) tick();
      chk("t1_hold_done", done, 32'd0);
      rst = 1'b1;
      tick();
      chk("t1_release_state", state_dbg, 32'd0);
      chk("t1_release_busy",  busy,      32'd0);
      din   = 8'hA5;
      start = 1'b1;
      run_frame("t1_refr", 1'b0, 16'b1010_1010_0101_0, 13, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
